// File: rtl/bfly_stage_ctrl.sv
// bfly_stage_ctrl: sequencing controller for one radix-2 butterfly stage.
// Counts input beats per frame. The first half-frame writes the delay shift
// register. The second half-frame reads it, enables the butterfly and
// addresses the twiddle ROM. valid_out is realigned to the butterfly latency.
// Optional feature macro: BFLY_CTRL_GAP_ERR_EN. When it is defined, a gap
// inside a frame aborts the frame and sets a sticky err flag. When it is not
// defined, a gap simply stalls the frame.
//
// state | meaning
// IDLE  | waiting for beat 0 of a frame
// FILL  | first half-frame, writing the delay shift register
// BFLY  | second half-frame, butterfly active
// DRAIN | BF_LAT cycles after the last beat; beat 0 of the next frame may arrive
module bfly_stage_ctrl #(
  parameter int NUM    = 16,
  parameter int DATA   = 512,
  parameter int COUNT  = DATA / NUM,
  parameter int HALF   = COUNT / 2,
  parameter int BF_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid_in,
  output logic                    sr_write,
  output logic                    sr_read,
  output logic                    bfly_en,
  output logic [$clog2(HALF)-1:0] tw_addr,
  output logic                    valid_out,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err
);

  localparam int CW = $clog2(COUNT);
  localparam int TW = $clog2(HALF);
  localparam int DW = $clog2(BF_LAT + 1);

  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] HM1_C  = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST_C = CW'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     in_cnt, in_cnt_nx;
  logic [DW-1:0]     drn_cnt, drn_cnt_nx;
  logic [BF_LAT-1:0] pipe_v, pipe_v_nx;
  logic [BF_LAT-1:0] pipe_l, pipe_l_nx;
  logic              busy_q;
  logic              lo_half;
  logic              beat_last;

  // Same-cycle strobes; held low during reset so nothing leaks out while rstn is low.
  always_comb begin
    lo_half   = (in_cnt < HALF_C);
    sr_write  = rstn && valid_in && lo_half;
    bfly_en   = rstn && valid_in && !lo_half;
    sr_read   = bfly_en;
    tw_addr   = bfly_en ? TW'(in_cnt - HALF_C) : '0;
    beat_last = bfly_en && (in_cnt == LAST_C);
  end

  // Next state and beat counter; DRAIN uses a down-counter to time BF_LAT cycles.
  always_comb begin
    state_nx   = state;
    in_cnt_nx  = in_cnt;
    drn_cnt_nx = drn_cnt;
    case (state)
      IDLE: begin
        if (valid_in) begin
          state_nx  = FILL;
          in_cnt_nx = CW'(1);
        end
      end
      FILL: begin
        if (valid_in) begin
          in_cnt_nx = in_cnt + CW'(1);
          if (in_cnt == HM1_C) state_nx = BFLY;
        end else begin
`ifdef BFLY_CTRL_GAP_ERR_EN
          state_nx  = IDLE;
          in_cnt_nx = '0;
`endif
        end
      end
      BFLY: begin
        if (valid_in) begin
          if (in_cnt == LAST_C) begin
            state_nx   = DRAIN;
            in_cnt_nx  = '0;
            drn_cnt_nx = DW'(BF_LAT - 1);
          end else begin
            in_cnt_nx = in_cnt + CW'(1);
          end
        end else begin
`ifdef BFLY_CTRL_GAP_ERR_EN
          state_nx  = IDLE;
          in_cnt_nx = '0;
`endif
        end
      end
      DRAIN: begin
        if (valid_in) begin
          state_nx  = FILL;
          in_cnt_nx = CW'(1);
        end else if (drn_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          drn_cnt_nx = drn_cnt - DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output pipeline: bfly_en shifted BF_LAT deep, tagged with the last-beat flag.
  always_comb begin
    pipe_v_nx    = '0;
    pipe_l_nx    = '0;
    pipe_v_nx[0] = bfly_en;
    pipe_l_nx[0] = beat_last;
    for (int i = 1; i < BF_LAT; i++) begin
      pipe_v_nx[i] = pipe_v[i-1];
      pipe_l_nx[i] = pipe_l[i-1];
    end
  end

  // Registers; busy is registered from the next-cycle state and pipeline contents.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      in_cnt  <= '0;
      drn_cnt <= '0;
      pipe_v  <= '0;
      pipe_l  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      in_cnt  <= in_cnt_nx;
      drn_cnt <= drn_cnt_nx;
      pipe_v  <= pipe_v_nx;
      pipe_l  <= pipe_l_nx;
      busy_q  <= (state_nx != IDLE) || (|pipe_v_nx);
    end
  end

`ifdef BFLY_CTRL_GAP_ERR_EN
  logic err_q;

  // Sticky gap error: a missing beat inside FILL or BFLY.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (!valid_in && (state == FILL || state == BFLY)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign valid_out  = pipe_v[BF_LAT-1];
  assign frame_done = pipe_v[BF_LAT-1] && pipe_l[BF_LAT-1];
  assign busy       = busy_q;

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Testbench for bfly_stage_ctrl: directed frame patterns followed by random
// valid_in/reset traffic, checked against a beat-index reference model.
module tb_bfly_stage_ctrl;

  localparam int COUNT  = 32;
  localparam int HALF   = 16;
  localparam int BF_LAT = 3;
  localparam int N      = 2600;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       valid_in = 1'b0;
  logic       sr_write, sr_read, bfly_en, valid_out, frame_done, busy, err;
  logic [3:0] tw_addr;

  bfly_stage_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .sr_write   (sr_write),
    .sr_read    (sr_read),
    .bfly_en    (bfly_en),
    .tw_addr    (tw_addr),
    .valid_out  (valid_out),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // reference model: position within the current frame plus a schedule of outputs
  int cur      = 0;
  int last_out = -1;
  bit err_m    = 1'b0;
  bit exp_vo [N+8];
  bit exp_fd [N+8];

  // stimulus
  bit rv [N];
  bit vv [N];
  int n_stim = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
  endtask

  task automatic push(input bit r, input bit v, input int len);
    for (int i = 0; i < len; i++) begin
      if (n_stim < N) begin
        rv[n_stim] = r;
        vv[n_stim] = v;
        n_stim++;
      end
    end
  endtask

  task automatic step(input bit r, input bit v);
    bit e_sw, e_be;
    int e_tw, beat;
    @(negedge clk);
    rstn     = r;
    valid_in = v;
    #1;
    beat = cur;
    e_sw = r && v && (beat < HALF);
    e_be = r && v && (beat >= HALF);
    e_tw = e_be ? beat - HALF : 0;
    chk("sr_write",   sr_write,   e_sw);
    chk("sr_read",    sr_read,    e_be);
    chk("bfly_en",    bfly_en,    e_be);
    chk("tw_addr",    tw_addr,    e_tw);
    chk("valid_out",  valid_out,  exp_vo[cyc]);
    chk("frame_done", frame_done, exp_fd[cyc]);
    chk("busy",       busy,       (cur != 0) || (last_out >= cyc));
    chk("err",        err,        err_m);
    // effect of the coming rising edge
    if (!r) begin
      cur      = 0;
      err_m    = 1'b0;
      last_out = -1;
      for (int k = cyc + 1; k < N + 8; k++) begin
        exp_vo[k] = 1'b0;
        exp_fd[k] = 1'b0;
      end
    end else if (v) begin
      if (e_be) begin
        exp_vo[cyc+BF_LAT] = 1'b1;
        exp_fd[cyc+BF_LAT] = (beat == COUNT - 1);
        last_out = cyc + BF_LAT;
      end
      cur = (cur + 1) % COUNT;
    end else if (cur != 0) begin
`ifdef BFLY_CTRL_GAP_ERR_EN
      err_m = 1'b1;
      cur   = 0;
`endif
    end
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < N + 8; k++) begin
      exp_vo[k] = 1'b0;
      exp_fd[k] = 1'b0;
    end
    // reset held with valid_in high
    push(1'b0, 1'b1, 5);
    // single frame
    push(1'b1, 1'b1, 32);
    push(1'b1, 1'b0, 8);
    // back-to-back frames
    push(1'b1, 1'b1, 64);
    push(1'b1, 1'b0, 8);
    // gap inside the first half-frame
    push(1'b1, 1'b1, 10);
    push(1'b1, 1'b0, 3);
    push(1'b1, 1'b1, 22);
    push(1'b1, 1'b0, 10);
    // reset mid-frame
    push(1'b1, 1'b1, 20);
    push(1'b0, 1'b1, 1);
    push(1'b1, 1'b1, 11);
    push(1'b1, 1'b0, 8);
    // clean restart, then random traffic with occasional bursts and resets
    push(1'b0, 1'b0, 2);
    while (n_stim < N) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 3)       push(1'b1, 1'b1, $urandom_range(20, 70));
      else if (kind == 9) push(($urandom_range(0, 3) != 0), 1'b0, $urandom_range(1, 3));
      else begin
        for (int i = 0; i < 20; i++) push(1'b1, ($urandom_range(0, 9) < 8), 1);
      end
    end

    @(posedge clk);
    for (int t = 0; t < N; t++) step(rv[t], vv[t]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
